store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer between the cpu's data port (dataAddr/writeData/we/readData)
//  and data memory. Stores retire into the buffer in one cycle; a drain engine
//  writes them to memory over a valid/ready port. Loads hit the youngest buffered
//  store to the same word (forwarding), otherwise read memory combinationally.
// PARAMETERS
//  DEPTH   4    entries; power of two, >= 2
//  AW      32   byte-address width; word compare uses [AW-1:2]
//  DW      32   data width
// PORTS
//  clk         in   1      clock, all state updates on posedge
//  n_reset     in   1      asynchronous active-low reset
//  dataAddr    in   AW     cpu load/store byte address
//  writeData   in   DW     cpu store data
//  we          in   1      cpu store request this cycle
//  readData    out  DW     load data to cpu (forwarded or mem_rdata)
//  stall       out  1      store refused this cycle (buffer full); cpu holds instr
//  empty       out  1      no pending stores (for fence/halt/testbench drain)
//  mem_raddr   out  AW     memory read address, = {dataAddr[AW-1:2],2'b00}
//  mem_rdata   in   DW     memory read data, combinational from mem_raddr
//  mem_wvalid  out  1      head entry valid for write
//  mem_wready  in   1      memory accepts write this cycle
//  mem_waddr   out  AW     head entry word address, bits [1:0] = 00
//  mem_wdata   out  DW     head entry data
// BEHAVIOUR
//  - Reset (async assert, sync release): head=tail=count=0; mem_wvalid=0,
//    stall=0, empty=1; entry contents unreset (don't-care). Reset mid-drain
//    discards pending stores; mem_wvalid falls immediately with n_reset.
//  - Enqueue: we && !full at posedge -> entry{dataAddr[AW-1:2],writeData} at tail,
//    tail++ mod DEPTH. Latency 1: visible to forwarding/mem_wvalid next cycle.
//  - stall = we && full (combinational, no dependence on mem_wready). A refused
//    store is not captured; the cpu re-presents it next cycle.
//  - Dequeue: mem_wvalid = !empty; head fields stable while mem_wvalid && !mem_wready.
//    mem_wvalid && mem_wready at posedge -> head++ mod DEPTH.
//  - Simultaneous enqueue+dequeue (not full): both occur, count unchanged.
//    When full, dequeue frees a slot only from the next cycle on.
//  - count is $clog2(DEPTH)+1 bits; full = count==DEPTH; pointers wrap modulo DEPTH.
//  - Forwarding: readData = data of youngest valid entry with addr == dataAddr[AW-1:2],
//    else mem_rdata. Search is age-ordered from tail-1 back to head. The entry being
//    dequeued this cycle still counts as valid. A store enqueued this cycle is NOT
//    forwarded to a load in the same cycle (single-cycle cpu never does both).
//  - dataAddr bits [1:0] are ignored (word-only lw/sw). readData is defined only when
//    dataAddr is known; with we=0 and dataAddr=X, no state changes.
//  - Memory ordering: writes reach memory strictly in program order; no coalescing.
// STRUCTURE
//  - r4_pkg: XLEN=32, typedef struct packed {logic [29:0] waddr; logic [31:0] data;}
//    sb_entry_t; localparam SB_DEPTH=4.
//  - Sub-module store_buffer_fwd: combinational youngest-match search over the entry
//    array + valid mask + head/tail; outputs hit and hit_data. FIFO control stays in top.
// TESTING
//  1 Reset: n_reset=0 with we=1 -> mem_wvalid=0, empty=1, stall=0; release -> unchanged.
//  2 Store/drain: we=1 @0x10 data 0x01FE, mem_wready=0 -> next cycle mem_wvalid=1,
//    mem_waddr=0x10, mem_wdata=0x01FE held 3 cycles; mem_wready=1 -> empty=1 next cycle.
//  3 Forwarding: stores 0x8<-0xAA then 0x8<-0xBB, mem_wready=0, mem_rdata=0x55, load 0x8
//    -> readData=0xBB; load 0xC -> 0x55; load 0xA -> 0xBB (low bits ignored).
//  4 Full: 4 stores with mem_wready=0 -> 5th we=1 gives stall=1, not captured; one
//    mem_wready pulse -> stall=0 next cycle, 5th store accepted; drain order 1..5.
//  5 Simultaneous: count=2, we=1 and mem_wready=1 same cycle -> count stays 2,
//    head/tail both advance; wrap past DEPTH-1 preserves order and data.
//  6 Reset mid-drain: 3 pending, assert n_reset between edges -> mem_wvalid=0 at once,
//    after release empty=1 and no further writes issued.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the cpu store buffer.
// The entry struct describes one posted store at the default 32-bit address/data width.
package store_buffer_pkg;
    localparam int XLEN     = 32;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_fwd.sv
// Load-forwarding search: finds the youngest valid buffered store to the queried word.
// Walks from oldest (head) to youngest so that later matches override earlier ones.
module store_buffer_fwd
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = XLEN,
    parameter int DW    = XLEN,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][AW-3:0] waddr_i,
    input  logic [DEPTH-1:0][DW-1:0] data_i,
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [PW-1:0]            head_i,
    input  logic [AW-3:0]            qaddr_i,
    output logic                     hit_o,
    output logic [DW-1:0]            hit_data_o
);

    logic [PW-1:0] idx;

    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PW'(i);
            if (valid_i[idx] && (waddr_i[idx] == qaddr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the cpu data port and data memory.
// Stores retire in one cycle into a circular FIFO; a drain port writes them out in order.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = XLEN,
    parameter int DW    = XLEN
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [AW-1:0] dataAddr,
    input  logic [DW-1:0] writeData,
    input  logic          we,
    output logic [DW-1:0] readData,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wvalid,
    input  logic          mem_wready,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [DEPTH-1:0][AW-3:0] waddr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [DEPTH-1:0]         valid;

    logic full, enq, deq, hit;
    logic [DW-1:0] hit_data;
    logic [PW-1:0] off;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign enq   = we && !full;
    assign deq   = !empty && mem_wready;
    assign stall = we && full;

    assign mem_wvalid = !empty;
    assign mem_waddr  = {waddr_q[head_q], 2'b00};
    assign mem_wdata  = data_q[head_q];
    assign mem_raddr  = dataAddr & ~AW'(3);

    always_comb begin
        head_d  = deq ? head_q + PW'(1) : head_q;
        tail_d  = enq ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            waddr_q[tail_q] <= dataAddr[AW-1:2];
            data_q[tail_q]  <= writeData;
        end
    end

    always_comb begin
        valid = '0;
        off   = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off      = PW'(j) - head_q;
            valid[j] = ({1'b0, off} < count_q);
        end
    end

    store_buffer_fwd #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) u_fwd (
        .waddr_i   (waddr_q),
        .data_i    (data_q),
        .valid_i   (valid),
        .head_i    (head_q),
        .qaddr_i   (dataAddr[AW-1:2]),
        .hit_o     (hit),
        .hit_data_o(hit_data)
    );

    assign readData = hit ? hit_data : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model of the posted-write buffer.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [31:0] dataAddr, writeData, readData, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic        we, stall, empty, mem_wvalid, mem_wready;

    int checks   = 0;
    int failures = 0;

    sb_entry_t q[$];

    always #5 clk = ~clk;

    store_buffer dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .dataAddr  (dataAddr),
        .writeData (writeData),
        .we        (we),
        .readData  (readData),
        .stall     (stall),
        .empty     (empty),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs vs model, advance model at posedge.
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic [31:0] rd, input string tag);
        logic [31:0] exp_rd;
        int          n;
        we = w; dataAddr = a; writeData = d; mem_wready = rdy; mem_rdata = rd;
        #1;
        n = q.size();
        exp_rd = rd;
        for (int i = 0; i < n; i++)
            if (q[i].waddr == a[31:2]) exp_rd = q[i].data;
        chk({tag, "_empty"}, 64'(empty), 64'(n == 0));
        chk({tag, "_stall"}, 64'(stall), 64'(w && n == 4));
        chk({tag, "_wvalid"}, 64'(mem_wvalid), 64'(n != 0));
        chk({tag, "_raddr"}, 64'(mem_raddr), 64'({a[31:2], 2'b00}));
        chk({tag, "_rdata"}, 64'(readData), 64'(exp_rd));
        if (n != 0) begin
            chk({tag, "_waddr"}, 64'(mem_waddr), 64'({q[0].waddr, 2'b00}));
            chk({tag, "_wdata"}, 64'(mem_wdata), 64'(q[0].data));
        end
        @(posedge clk);
        if (n != 0 && rdy) void'(q.pop_front());
        if (w && n < 4) q.push_back('{waddr: a[31:2], data: d});
        @(negedge clk);
    endtask

    initial begin
        int k;
        n_reset = 1'b0; we = 1'b1; dataAddr = 32'h40; writeData = 32'h1234;
        mem_wready = 1'b0; mem_rdata = 32'h0;

        // 1: reset holds state empty even with a store request
        @(negedge clk); @(negedge clk);
        #1;
        chk("t1_wvalid", 64'(mem_wvalid), 64'd0);
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_stall", 64'(stall), 64'd0);
        @(negedge clk);
        we = 1'b0;
        n_reset = 1'b1;
        #1;
        chk("t1_rel_empty", 64'(empty), 64'd1);
        chk("t1_rel_wvalid", 64'(mem_wvalid), 64'd0);
        @(negedge clk);

        // 2: single store held until accepted
        step(1, 32'h10, 32'h01FE, 0, 32'h0, "t2_st");
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_hold_waddr", 64'(mem_waddr), 64'h10);
            chk("t2_hold_wdata", 64'(mem_wdata), 64'h01FE);
            step(0, 32'h0, 32'h0, 0, 32'h0, "t2_hold");
        end
        step(0, 32'h0, 32'h0, 1, 32'h0, "t2_drain");
        #1;
        chk("t2_empty_after", 64'(empty), 64'd1);

        // 3: forwarding picks youngest, low address bits ignored
        step(1, 32'h8, 32'hAA, 0, 32'h55, "t3_st1");
        step(1, 32'h8, 32'hBB, 0, 32'h55, "t3_st2");
        we = 0; dataAddr = 32'h8; mem_rdata = 32'h55; #1;
        chk("t3_ld8", 64'(readData), 64'hBB);
        dataAddr = 32'hC; #1;
        chk("t3_ldC", 64'(readData), 64'h55);
        dataAddr = 32'hA; #1;
        chk("t3_ldA", 64'(readData), 64'hBB);
        @(negedge clk);
        step(0, 32'h8, 32'h0, 1, 32'h55, "t3_dr1");
        step(0, 32'h8, 32'h0, 1, 32'h55, "t3_dr2");

        // 4: full buffer refuses, then accepts after a single drain
        for (int i = 1; i <= 4; i++)
            step(1, 32'h100 + 32'(i * 4), 32'(i), 0, 32'h0, "t4_fill");
        step(1, 32'h114, 32'd5, 0, 32'h0, "t4_refused");
        #1;
        chk("t4_stall_still", 64'(stall), 64'd1);
        step(1, 32'h114, 32'd5, 1, 32'h0, "t4_pulse");
        #1;
        chk("t4_stall_clear", 64'(stall), 64'd0);
        step(1, 32'h114, 32'd5, 0, 32'h0, "t4_accept");
        for (int i = 2; i <= 5; i++) begin
            #1;
            chk("t4_order", 64'(mem_wdata), 64'(i));
            step(0, 32'h0, 32'h0, 1, 32'h0, "t4_drain");
        end

        // 5: simultaneous enqueue/dequeue at count 2, wrapping pointers
        step(1, 32'h200, 32'hA0, 0, 32'h0, "t5_a");
        step(1, 32'h204, 32'hA1, 0, 32'h0, "t5_b");
        for (int i = 2; i < 8; i++)
            step(1, 32'h200 + 32'(i * 4), 32'hA0 + 32'(i), 1, 32'h0, "t5_sim");
        #1;
        chk("t5_count2_head", 64'(mem_wdata), 64'hA6);
        step(0, 32'h0, 32'h0, 1, 32'h0, "t5_d1");
        step(0, 32'h0, 32'h0, 1, 32'h0, "t5_d2");

        // 6: reset mid-drain discards pending stores immediately
        for (int i = 0; i < 3; i++)
            step(1, 32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 0, 32'h0, "t6_fill");
        we = 0; #2;
        n_reset = 1'b0; #1;
        chk("t6_wvalid_async", 64'(mem_wvalid), 64'd0);
        chk("t6_empty_async", 64'(empty), 64'd1);
        q.delete();
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++)
            step(0, 32'h300, 32'h0, 1, 32'h77, "t6_post");

        // Random traffic against the model
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 6), {24'h0, 3'($urandom_range(0, 7)), 3'b0, 2'($urandom)},
                 $urandom, ($urandom_range(0, 1) == 1), $urandom, "rnd");

        // Bounded final drain
        k = 0;
        while (q.size() != 0 && k < 20) begin
            step(0, 32'h0, 32'h0, 1, 32'h0, "fin");
            k++;
        end
        chk("fin_drained", 64'(q.size() == 0), 64'd1);
        #1;
        chk("fin_empty", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
